// File: rtl/shift_pkg.sv
// shift_pkg: definitions shared by the shift execute stages.
//   DATA_W / HALF_W : full operand width and split-mode half width.
//   OP_*            : 2-bit shift opcodes carried by issue micro-ops.
//   decode_op()     : opcode -> shifter direction/arithmetic controls.
package shift_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef struct packed {
    logic dir;    // 1 = right shift
    logic arith;  // 1 = sign-fill on right shift
  } shift_ctl_t;

  // The reserved opcode decodes to a plain left/logical shift; the caller
  // also forces the amount to zero so the operand passes through untouched.
  function automatic shift_ctl_t decode_op(input logic [1:0] op);
    shift_ctl_t ctl;
    ctl.dir   = (op == OP_SRL) || (op == OP_SRA);
    ctl.arith = (op == OP_SRA);
    return ctl;
  endfunction

  function automatic logic is_rsvd(input logic [1:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/flexible_shifter_structural.sv
// flexible_shifter_structural: combinational 64-bit shifter, either one
// unified 64-bit shift or two independent 32-bit shifts.
//   data_in      : operand
//   mode_unified : 1 = single 64-bit shift using the hi controls
//   amt_hi       : unified amount (6 bits) / high-half amount ([4:0])
//   dir_hi/arith_hi : direction and arithmetic select, unified or high half
//   amt_lo, dir_lo, arith_lo : low-half controls (split mode only)
//   data_out     : shifted result
module flexible_shifter_structural (
  input  logic [63:0] data_in,
  input  logic        mode_unified,
  input  logic [5:0]  amt_hi,
  input  logic        dir_hi,
  input  logic        arith_hi,
  input  logic [4:0]  amt_lo,
  input  logic        dir_lo,
  input  logic        arith_lo,
  output logic [63:0] data_out
);

  function automatic logic [63:0] shift64(input logic [63:0] v, input logic [5:0] amt,
                                          input logic dir, input logic arith);
    logic signed [63:0] sv;
    sv = $signed(v);
    if (!dir)       return v << amt;
    else if (arith) return sv >>> amt;
    else            return v >> amt;
  endfunction

  function automatic logic [31:0] shift32(input logic [31:0] v, input logic [4:0] amt,
                                          input logic dir, input logic arith);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (!dir)       return v << amt;
    else if (arith) return sv >>> amt;
    else            return v >> amt;
  endfunction

  always_comb begin
    data_out = '0;
    if (mode_unified) begin
      data_out = shift64(data_in, amt_hi, dir_hi, arith_hi);
    end else begin
      data_out[63:32] = shift32(data_in[63:32], amt_hi[4:0], dir_hi, arith_hi);
      data_out[31:0]  = shift32(data_in[31:0], amt_lo, dir_lo, arith_lo);
    end
  end

endmodule

// File: rtl/shift_out_fifo.sv
// shift_out_fifo: synchronous in-order FIFO with occupancy count.
//   DEPTH (power of two, >= 2), WIDTH : geometry
//   push/push_data : write side (ignored when full)
//   pop            : read side, advances the head (ignored when empty)
//   head_data      : oldest entry (meaningful only when count != 0)
//   count          : number of stored entries, 0..DEPTH
module shift_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count < FULL_CNT);
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: registered execute stage around the combinational
// shifter. Captures a decoded shift op (stage A), shifts it, and queues
// {result, tag, err} in an in-order output FIFO for writeback.
//   in_valid/in_ready   : issue handshake; in_ready depends on state only
//   in_split, in_op_hi, in_op_lo, in_amt_a, in_amt_b, in_data, in_tag : op
//   out_valid/out_ready : writeback handshake
//   out_data, out_tag, out_err : head-of-FIFO result (zero when empty)
//   ops_done            : count of completed output handshakes (wraps)
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_split,
  input  logic [1:0]       in_op_hi,
  input  logic [1:0]       in_op_lo,
  input  logic [5:0]       in_amt_a,
  input  logic [4:0]       in_amt_b,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [31:0]      ops_done
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int ENT_W = DATA_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

  logic              vld_p0;
  logic              split_p0;
  logic [1:0]        op_hi_p0;
  logic [1:0]        op_lo_p0;
  logic [5:0]        amt_a_p0;
  logic [4:0]        amt_b_p0;
  logic [DATA_W-1:0] data_p0;
  logic [TAG_W-1:0]  tag_p0;

  logic              accept;
  logic              advance;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_has_room;

  shift_ctl_t        ctl_hi;
  shift_ctl_t        ctl_lo;
  logic              rsvd;
  logic              sh_dir_hi;
  logic              sh_arith_hi;
  logic              sh_dir_lo;
  logic              sh_arith_lo;
  logic [5:0]        sh_amt_hi;
  logic [4:0]        sh_amt_lo;
  logic [DATA_W-1:0] sh_result;

  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  head_ent;

  assign fifo_has_room = fifo_count < FULL_CNT;
  assign in_ready      = !vld_p0 || fifo_has_room;
  assign accept        = in_valid && in_ready;
  assign advance       = vld_p0 && fifo_has_room;
  assign out_valid     = fifo_count != '0;
  assign pop           = out_valid && out_ready;

  // ---- stage A: capture register ----
  always_ff @(posedge clk) begin
    if (rst)          vld_p0 <= 1'b0;
    else if (accept)  vld_p0 <= 1'b1;
    else if (advance) vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      split_p0 <= in_split;
      op_hi_p0 <= in_op_hi;
      op_lo_p0 <= in_op_lo;
      amt_a_p0 <= in_amt_a;
      amt_b_p0 <= in_amt_b;
      data_p0  <= in_data;
      tag_p0   <= in_tag;
    end
  end

  // A reserved opcode in any active half neutralises the whole op so the
  // operand passes through unchanged and is flagged for writeback.
  always_comb begin
    ctl_hi      = decode_op(op_hi_p0);
    ctl_lo      = decode_op(op_lo_p0);
    rsvd        = is_rsvd(op_hi_p0) || (split_p0 && is_rsvd(op_lo_p0));
    sh_dir_hi   = ctl_hi.dir;
    sh_arith_hi = ctl_hi.arith;
    sh_dir_lo   = ctl_lo.dir;
    sh_arith_lo = ctl_lo.arith;
    sh_amt_hi   = split_p0 ? {1'b0, amt_a_p0[4:0]} : amt_a_p0;
    sh_amt_lo   = amt_b_p0;
    if (rsvd) begin
      sh_dir_hi   = 1'b0;
      sh_arith_hi = 1'b0;
      sh_dir_lo   = 1'b0;
      sh_arith_lo = 1'b0;
      sh_amt_hi   = '0;
      sh_amt_lo   = '0;
    end
  end

  flexible_shifter_structural u_shifter (
    .data_in      (data_p0),
    .mode_unified (!split_p0),
    .amt_hi       (sh_amt_hi),
    .dir_hi       (sh_dir_hi),
    .arith_hi     (sh_arith_hi),
    .amt_lo       (sh_amt_lo),
    .dir_lo       (sh_dir_lo),
    .arith_lo     (sh_arith_lo),
    .data_out     (sh_result)
  );

  // ---- stage B: output FIFO ----
  assign push_ent = {sh_result, tag_p0, rsvd};

  shift_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENT_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (advance),
    .push_data (push_ent),
    .pop       (pop),
    .head_data (head_ent),
    .count     (fifo_count)
  );

  // Storage is not reset, so outputs are masked to zero while empty.
  assign out_data = out_valid ? head_ent[ENT_W-1 -: DATA_W] : '0;
  assign out_tag  = out_valid ? head_ent[TAG_W:1] : '0;
  assign out_err  = out_valid ? head_ent[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst)      ops_done <= '0;
    else if (pop) ops_done <= ops_done + 32'd1;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Registered execute stage that wraps the existing `flexible_shifter_structural` datapath behind valid/ready handshakes. It accepts a decoded shift micro-op from issue logic, drives the shifter's unified or split controls from a captured operand register, and buffers the result in a small in-order output FIFO for writeback. It decouples the purely combinational shifter from both issue backpressure and writeback stalls.

## Interface

Parameters:
- `OUT_DEPTH`, default 2: output FIFO entries. Must be a power of two and at least 2.
- `TAG_W`, default 4: width of the opaque tag passed through with each op.

Ports (clock and reset first):
- `clk`  in  1  sole clock. Everything is rising-edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  upstream op valid.
- `in_ready`  out  1  stage can accept an op.
- `in_split`  in  1  0 = one 64-bit shift; 1 = two independent 32-bit shifts.
- `in_op_hi`  in  2  op for unified mode or for the high half: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- `in_op_lo`  in  2  op for the low half. Used only when `in_split`=1.
- `in_amt_a`  in  6  unified shift amount. In split mode, `[4:0]` is the high-half amount.
- `in_amt_b`  in  5  low-half amount. Used only when `in_split`=1.
- `in_data`  in  64  operand.
- `in_tag`  in  TAG_W  pass-through tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  64  shifted result.
- `out_tag`  out  TAG_W  tag of the result.
- `out_err`  out  1  op was illegal (reserved opcode).
- `ops_done`  out  32  count of completed output handshakes.

## Operation

- **Stage A (capture register).**
  - Loads all `in_*` fields when `in_valid && in_ready`, and sets `a_valid`.
  - `in_ready = !a_valid || (fifo_count < OUT_DEPTH)`. It depends only on registered state; there is no combinational path from `out_ready`.
- **Shifter drive.** The shifter is fed combinationally from stage A.
  - `mode_unified = !split`.
  - dir = 1 for SRL and SRA; arith = 1 for SRA only.
  - Unified mode uses `in_op_hi` and `in_amt_a`. Split mode uses hi from `in_op_hi`/`in_amt_a[4:0]` and lo from `in_op_lo`/`in_amt_b`.
- **Reserved opcode.** Any reserved opcode in use (either half in split mode) forces:
  - shifter amount 0, left, logical;
  - result equal to the operand, unmodified;
  - `err` = 1.
- **Advance into the FIFO.**
  - When `a_valid && fifo_count < OUT_DEPTH`, {result, tag, err} is pushed.
  - `a_valid` clears unless a new op is accepted in the same cycle.
- **FIFO.**
  - Strictly in order.
  - Pop on `out_valid && out_ready`.
  - `out_*` are driven from the head entry; `out_valid = fifo_count != 0`.
  - Push and pop in the same cycle leaves the count unchanged.
  - Read/write pointers wrap modulo `OUT_DEPTH`.
- **ops_done.** Increments on each output handshake and wraps at 2^32.
- **Reset values.**
  - `a_valid` = 0, `fifo_count` = 0, pointers = 0, `ops_done` = 0.
  - Outputs: `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `out_tag` = 0, `out_err` = 0.
- **Reset mid-operation.** Any in-flight op is discarded. No partial result ever appears.

## Timing

- **Latency.** An op accepted at edge N appears with `out_valid` = 1 after edge N+1 (A→FIFO at N+1). That is 2 cycles from issue to result visibility.
- **Throughput.** One op per cycle when `out_ready` is held high.
- **Backpressure.**
  - With `out_ready` = 0, the stage holds `OUT_DEPTH` + 1 ops: the FIFO plus stage A.
  - `in_ready` falls in the cycle after the A register fills while the FIFO is full.
- **FIFO full with A valid.** A holds. A pop frees a slot, and A advances on the following edge.
- **Output stability.** While `out_valid && !out_ready`, `out_data`, `out_tag` and `out_err` must stay stable.

## Structure

- **Shared package `shift_pkg`:**
  - opcode localparams `OP_SLL` / `OP_SRL` / `OP_SRA` / `OP_RSVD`;
  - the op-to-(dir, arith) decode function;
  - data width 64 and half-width 32 constants.
- **Sub-modules:**
  - Instantiate `flexible_shifter_structural` unmodified.
  - Factor the buffer into `shift_out_fifo`, a parameterised depth/width synchronous FIFO with count, reused by other execute stages.

## Test plan

1. **Unified SLL.** Unified SLL, amt 4, data FEDCBA9876543210, `out_ready` = 1 → `out_data` EDCBA98765432100, `out_err` = 0. `out_valid` rises exactly 2 cycles after accept.
2. **Unified right shifts, back-to-back.** Unified SRL 8 then SRA 8 on FEDCBA9876543210 → 00FEDCBA98765432, then FFFEDCBA98765432, on consecutive cycles (full throughput).
3. **Split SRA.** Split, hi SRA 4, lo SRA 4, data 80000000F0000000 → F8000000FF000000. Then split with hi SLL 4 and lo SRL 4 on FEDCBA9876543210 → EDCBA98007654321.
4. **Reserved opcode.** Split with `in_op_lo` = 11, data 0123456789ABCDEF → `out_data` 0123456789ABCDEF, `out_err` = 1, tag preserved.
5. **Backpressure.** Hold `out_ready` = 0 and issue tags 1, 2, 3, 4 → `in_ready` drops with 3 held (4 stalled). Release `out_ready` → tags emerge 1, 2, 3, 4 in order with no loss or duplication, and `ops_done` = 4.
6. **Reset mid-flight.** Assert `rst` for one cycle with 2 ops in the FIFO and 1 in A → next cycle `out_valid` = 0, `in_ready` = 1, `ops_done` = 0. No stale result appears after release.
